// File: rtl/plic_pkg.sv
// Shared PLIC definitions: TileLink-UL opcodes, PLIC register map offsets and
// the claim sequencer state encoding.
package plic_pkg;

  localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_A_GET             = 3'd4;
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  localparam int PLIC_AW = 22;

  localparam logic [PLIC_AW-1:0] PLIC_PRIO_BASE  = 22'h000000;
  localparam logic [PLIC_AW-1:0] PLIC_EN_BASE    = 22'h002000;
  localparam logic [PLIC_AW-1:0] PLIC_EN_STRIDE  = 22'h000080;
  localparam logic [PLIC_AW-1:0] PLIC_CTX_BASE   = 22'h200000;
  localparam logic [PLIC_AW-1:0] PLIC_CTX_STRIDE = 22'h001000;
  localparam logic [PLIC_AW-1:0] PLIC_CLAIM_OFS  = 22'h000004;

  typedef enum logic [3:0] {
    ST_INIT_PRIO_A = 4'd0,
    ST_INIT_PRIO_D = 4'd1,
    ST_INIT_EN_A   = 4'd2,
    ST_INIT_EN_D   = 4'd3,
    ST_INIT_THR_A  = 4'd4,
    ST_INIT_THR_D  = 4'd5,
    ST_IDLE        = 4'd6,
    ST_CLAIM_A     = 4'd7,
    ST_CLAIM_D     = 4'd8,
    ST_PEND        = 4'd9,
    ST_SERVICE     = 4'd10,
    ST_COMPLETE_A  = 4'd11,
    ST_COMPLETE_D  = 4'd12
  } seq_state_e;

  function automatic logic is_d_state(input seq_state_e st);
    return (st == ST_INIT_PRIO_D) || (st == ST_INIT_EN_D) || (st == ST_INIT_THR_D) ||
           (st == ST_CLAIM_D) || (st == ST_COMPLETE_D);
  endfunction

endpackage

// File: rtl/plic_claim_sequencer.sv
// TileLink-UL master that programs one PLIC context, then claims, presents and
// completes interrupts for a single hart.
module plic_claim_sequencer
  import plic_pkg::*;
#(
  parameter int                CONTEXT   = 0,
  parameter int                TL_RS     = 4,
  parameter logic [TL_RS-1:0]  SOURCE_ID = '0,
  parameter logic [31:0]       PRIO_MASK = 32'hFFFF_FFFE,
  parameter logic [31:0]       EN_MASK   = 32'hFFFF_FFFE
) (
  input  logic             seq_clock_i,
  input  logic             seq_reset_i,
  input  logic             irq_i,
  // Handshake: a beat moves on a channel in any cycle where valid and ready
  // are both 1; the A payload is a pure function of state, so it cannot change
  // while a_valid waits for a_ready.
  output logic [2:0]       seq_a_opcode,
  output logic [2:0]       seq_a_param,
  output logic [3:0]       seq_a_size,
  output logic [TL_RS-1:0] seq_a_source,
  output logic [21:0]      seq_a_address,
  output logic [3:0]       seq_a_mask,
  output logic [31:0]      seq_a_data,
  output logic             seq_a_corrupt,
  output logic             seq_a_valid,
  input  logic             seq_a_ready,
  input  logic [2:0]       seq_d_opcode,
  input  logic [1:0]       seq_d_param,
  input  logic [3:0]       seq_d_size,
  input  logic [TL_RS-1:0] seq_d_source,
  input  logic             seq_d_denied,
  input  logic [31:0]      seq_d_data,
  input  logic             seq_d_corrupt,
  input  logic             seq_d_valid,
  output logic             seq_d_ready,
  output logic             core_irq_o,
  output logic [4:0]       core_irq_id_o,
  input  logic             core_ack_i,
  input  logic             core_done_i,
  output logic             init_done_o,
  output logic             err_o
);

  localparam logic [21:0] EN_ADDR    = PLIC_EN_BASE + PLIC_EN_STRIDE * 22'(CONTEXT);
  localparam logic [21:0] THR_ADDR   = PLIC_CTX_BASE + PLIC_CTX_STRIDE * 22'(CONTEXT);
  localparam logic [21:0] CLAIM_ADDR = THR_ADDR + PLIC_CLAIM_OFS;

  seq_state_e state_q, state_d;
  logic [4:0] src_q, src_d;
  logic [4:0] id_q, id_d;
  logic       run_q;
  logic       init_done_q, init_done_d;
  logic       err_q, err_d;

  logic a_fire;
  logic d_fire;
  logic d_bad;
  logic unused_d;

  assign a_fire   = seq_a_valid & seq_a_ready;
  assign d_fire   = seq_d_valid & run_q;
  assign d_bad    = seq_d_denied | seq_d_corrupt;
  assign unused_d = ^{seq_d_param, seq_d_size, seq_d_source, seq_d_data[31:5]};

  always_ff @(posedge seq_clock_i or negedge seq_reset_i) begin
    if (!seq_reset_i) begin
      state_q     <= ST_INIT_PRIO_A;
      src_q       <= 5'd1;
      id_q        <= 5'd0;
      run_q       <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      id_q        <= id_d;
      run_q       <= 1'b1;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  // Beats outside a *_D state fall through the case untouched and are dropped.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    id_d        = id_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    if (d_fire && is_d_state(state_q) && d_bad) err_d = 1'b1;
    case (state_q)
      ST_INIT_PRIO_A: if (a_fire) state_d = ST_INIT_PRIO_D;
      ST_INIT_PRIO_D: begin
        if (d_fire) begin
          if (src_q == 5'd31) begin
            state_d = ST_INIT_EN_A;
          end else begin
            src_d   = src_q + 5'd1;
            state_d = ST_INIT_PRIO_A;
          end
        end
      end
      ST_INIT_EN_A:   if (a_fire) state_d = ST_INIT_EN_D;
      ST_INIT_EN_D:   if (d_fire) state_d = ST_INIT_THR_A;
      ST_INIT_THR_A:  if (a_fire) state_d = ST_INIT_THR_D;
      ST_INIT_THR_D: begin
        if (d_fire) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE:        if (irq_i) state_d = ST_CLAIM_A;
      ST_CLAIM_A:     if (a_fire) state_d = ST_CLAIM_D;
      ST_CLAIM_D: begin
        // A zero ID, a faulty beat or a non-data ack is treated as spurious.
        if (d_fire) begin
          if (!d_bad && (seq_d_opcode == TL_D_ACCESS_ACK_DATA) && (seq_d_data[4:0] != 5'd0)) begin
            id_d    = seq_d_data[4:0];
            state_d = ST_PEND;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_PEND: begin
        if (core_done_i)     state_d = ST_COMPLETE_A;
        else if (core_ack_i) state_d = ST_SERVICE;
      end
      ST_SERVICE:     if (core_done_i) state_d = ST_COMPLETE_A;
      ST_COMPLETE_A:  if (a_fire) state_d = ST_COMPLETE_D;
      ST_COMPLETE_D: begin
        if (d_fire) begin
          state_d = ST_IDLE;
          id_d    = 5'd0;
        end
      end
      default:        state_d = ST_INIT_PRIO_A;
    endcase
  end

  always_comb begin
    seq_a_valid   = 1'b0;
    seq_a_opcode  = TL_A_PUT_FULL;
    seq_a_address = 22'd0;
    seq_a_data    = 32'd0;
    core_irq_o    = 1'b0;
    case (state_q)
      ST_INIT_PRIO_A: begin
        seq_a_valid   = run_q;
        seq_a_address = PLIC_PRIO_BASE | {15'd0, src_q, 2'b00};
        seq_a_data    = {31'd0, PRIO_MASK[src_q]};
      end
      ST_INIT_EN_A: begin
        seq_a_valid   = run_q;
        seq_a_address = EN_ADDR;
        seq_a_data    = EN_MASK;
      end
      ST_INIT_THR_A: begin
        seq_a_valid   = run_q;
        seq_a_address = THR_ADDR;
        seq_a_data    = 32'd1;
      end
      ST_CLAIM_A: begin
        seq_a_valid   = run_q;
        seq_a_opcode  = TL_A_GET;
        seq_a_address = CLAIM_ADDR;
      end
      ST_PEND:        core_irq_o = 1'b1;
      ST_COMPLETE_A: begin
        seq_a_valid   = run_q;
        seq_a_address = CLAIM_ADDR;
        seq_a_data    = {27'd0, id_q};
      end
      default: ;
    endcase
  end

  assign seq_a_param   = 3'd0;
  assign seq_a_size    = 4'd2;
  assign seq_a_source  = SOURCE_ID;
  assign seq_a_mask    = 4'hF;
  assign seq_a_corrupt = 1'b0;
  assign seq_d_ready   = run_q;
  assign core_irq_id_o = id_q;
  assign init_done_o   = init_done_q;
  assign err_o         = err_q;

endmodule
